// File: rtl/ecc_fifo_pkg.sv
// Shared constants, codeword layout helpers and decode status for the ECC-protected FIFO.
// Used by both the write-side encoder and the read stage.
package ecc_fifo_pkg;

  localparam int DATA_W = 32;
  localparam int CODE_W = DATA_W + 7;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 16;
  localparam int SYN_W  = 6;

  localparam int CHECK_POS [SYN_W] = '{1, 2, 4, 8, 16, 32};

  typedef enum logic [1:0] {
    ECC_OK  = 2'd0,
    ECC_SBE = 2'd1,
    ECC_DBE = 2'd2
  } ecc_status_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    ecc_status_e       status;
  } entry_t;

  // Hamming position of data bit d: skip every power-of-two position already passed.
  function automatic int data_pos(input int d);
    return d + 3 + int'(d >= 1) + int'(d >= 4) + int'(d >= 11) + int'(d >= 26);
  endfunction

  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] cw);
    logic [DATA_W-1:0] data;
    data = '0;
    for (int d = 0; d < DATA_W; d++) data[d] = cw[data_pos(d)];
    return data;
  endfunction

  function automatic logic [CODE_W-1:0] secded_encode(input logic [DATA_W-1:0] data);
    logic [CODE_W-1:0] cw;
    logic [SYN_W-1:0]  syn;
    cw  = '0;
    syn = '0;
    for (int d = 0; d < DATA_W; d++) cw[data_pos(d)] = data[d];
    for (int i = 1; i < CODE_W; i++) if (cw[i]) syn = syn ^ SYN_W'(i);
    for (int c = 0; c < SYN_W; c++) cw[CHECK_POS[c]] = syn[c];
    cw[0] = ^cw;
    return cw;
  endfunction

endpackage

// File: rtl/ecc_fifo_read_stage_if.sv
// Show-ahead valid/ready output bus of the read stage: head entry payload plus error flags.
interface ecc_fifo_read_stage_if;
  import ecc_fifo_pkg::*;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              sbe;
  logic              dbe;

  modport master (output valid, data, sbe, dbe, input ready);
  modport slave  (input valid, data, sbe, dbe, output ready);

endinterface

// File: rtl/secded_decode_39_32.sv
// Combinational SECDED decoder: 39-bit codeword -> corrected 32-bit data, error flags, syndrome.
module secded_decode_39_32
  import ecc_fifo_pkg::*;
(
  input  logic [CODE_W-1:0] cw,
  output logic [DATA_W-1:0] data,
  output logic              sbe,
  output logic              dbe,
  output logic [SYN_W-1:0]  syn
);

  logic              par;
  logic [CODE_W-1:0] fixed;

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves a latch behind.
    syn   = '0;
    par   = ^cw;
    fixed = cw;
    sbe   = 1'b0;
    dbe   = 1'b0;
    for (int i = 1; i < CODE_W; i++) if (cw[i]) syn = syn ^ SYN_W'(i);

    if (syn == '0) begin
      sbe = par;                         // lone parity-bit flip leaves data intact
    end else if (par && int'(syn) < CODE_W) begin
      fixed = cw ^ (CODE_W'(1) << syn);
      sbe   = 1'b1;
    end else begin
      dbe = 1'b1;
    end
    data = extract_data(fixed);
  end

endmodule

// File: rtl/ecc_fifo_read_stage.sv
// Read side of the ECC FIFO: read pointer, 1-cycle memory read tracking, SECDED decode,
// 2-entry show-ahead output buffer and saturating error counters.
module ecc_fifo_read_stage
  import ecc_fifo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W:0]      wr_ptr,
  output logic [ADDR_W:0]      rd_ptr,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [CODE_W-1:0]    mem_rd_word,
  ecc_fifo_read_stage_if.master head,
  output logic [CNT_W-1:0]     sbe_count,
  output logic [CNT_W-1:0]     dbe_count
);

  logic              inflight;
  entry_t            entries [2];
  logic [1:0]        buf_cnt;
  logic              empty, pop, push;
  logic [1:0]        occ_after;
  logic [DATA_W-1:0] dec_data;
  logic              dec_sbe, dec_dbe;
  logic [SYN_W-1:0]  dec_syn;
  entry_t            new_entry;

  secded_decode_39_32 u_dec (
    .cw   (mem_rd_word),
    .data (dec_data),
    .sbe  (dec_sbe),
    .dbe  (dec_dbe),
    .syn  (dec_syn)
  );

  assign new_entry.data   = dec_data;
  assign new_entry.status = dec_dbe ? ECC_DBE : (dec_sbe ? ECC_SBE : ECC_OK);

  // A read is only issued if its word is guaranteed a buffer slot when it lands.
  assign empty       = (rd_ptr == wr_ptr);
  assign pop         = head.valid && head.ready;
  assign push        = inflight;
  assign occ_after   = buf_cnt + {1'b0, inflight} - {1'b0, pop};
  assign mem_rd_en   = rst_n && !empty && (occ_after < 2'd2);
  assign mem_rd_addr = rd_ptr[ADDR_W-1:0];

  assign head.valid = (buf_cnt != 2'd0);
  assign head.data  = entries[0].data;
  assign head.sbe   = (entries[0].status == ECC_SBE);
  assign head.dbe   = (entries[0].status == ECC_DBE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      inflight   <= 1'b0;
      buf_cnt    <= '0;
      // NOTE: the buffer storage is reset too, because the head entry drives out_data directly.
      entries[0] <= '0;
      entries[1] <= '0;
      sbe_count  <= '0;
      dbe_count  <= '0;
    end else begin
      // NOTE: state updates use <= so every register samples pre-edge values, independent of order.
      inflight <= mem_rd_en;
      if (mem_rd_en) rd_ptr <= rd_ptr + 1'b1;

      case ({push, pop})
        2'b10: begin
          entries[buf_cnt[0]] <= new_entry;
          buf_cnt             <= buf_cnt + 2'd1;
        end
        2'b01: begin
          entries[0] <= entries[1];
          buf_cnt    <= buf_cnt - 2'd1;
        end
        2'b11: begin
          if (buf_cnt == 2'd1) begin
            entries[0] <= new_entry;
          end else begin
            entries[0] <= entries[1];
            entries[1] <= new_entry;
          end
        end
        default: ;
      endcase

      if (push && new_entry.status == ECC_SBE && sbe_count != '1) sbe_count <= sbe_count + 1'b1;
      if (push && new_entry.status == ECC_DBE && dbe_count != '1) dbe_count <= dbe_count + 1'b1;
    end
  end

  a_ptr_span: assert property (@(posedge clk) disable iff (!rst_n)
    (ADDR_W+1)'(wr_ptr - rd_ptr) <= (ADDR_W+1)'(1 << ADDR_W));

  a_sbe_syn: assert property (@(posedge clk) disable iff (!rst_n)
    (inflight && dec_sbe) |-> (int'(dec_syn) < CODE_W));

endmodule

// File: tb/tb_ecc_fifo_read_stage.sv
// Randomized self-checking bench for ecc_fifo_read_stage with a queue-based reference model.
module tb_ecc_fifo_read_stage;
  import ecc_fifo_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic        sbe;
    logic        dbe;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  wr_ptr = '0;
  logic [4:0]  rd_ptr;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [38:0] mem_rd_word = '0;
  logic [15:0] sbe_count, dbe_count;

  ecc_fifo_read_stage_if head ();

  ecc_fifo_read_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_word (mem_rd_word),
    .head        (head),
    .sbe_count   (sbe_count),
    .dbe_count   (dbe_count)
  );

  always #5 clk = ~clk;

  // Synchronous memory with 1-cycle read latency.
  logic [38:0] mem [16];
  always @(posedge clk) if (mem_rd_en) mem_rd_word <= mem[mem_rd_addr];

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb [$];
  int   exp_sbe  = 0;
  int   exp_dbe  = 0;
  logic saw_wrap = 1'b0;
  logic [4:0] prev_rd = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Reference encoder: data bits fill non-power-of-two positions ascending, check bits
  // zero the index-XOR, bit 0 makes overall parity even.
  function automatic logic [38:0] ref_encode(input logic [31:0] d);
    logic [38:0] cw;
    logic [5:0]  s;
    int          k;
    cw = '0; s = '0; k = 0;
    for (int p = 1; p < 39; p++)
      if (!is_pow2(p)) begin
        cw = cw | (39'(d[k]) << p);
        k++;
      end
    for (int p = 1; p < 39; p++) if (cw[p]) s = s ^ 6'(p);
    for (int b = 0; b < 6; b++) cw = cw | (39'(s[b]) << (1 << b));
    cw = cw | 39'(^cw);
    return cw;
  endfunction

  function automatic logic [31:0] ref_extract(input logic [38:0] cw);
    logic [31:0] d;
    int          k;
    d = '0; k = 0;
    for (int p = 1; p < 39; p++)
      if (!is_pow2(p)) begin
        d = d | (32'(cw[p]) << k);
        k++;
      end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // fa/fb: codeword bits to flip, -1 for none. One flip is always correctable, two never are.
  task automatic write_word(input logic [31:0] d, input int fa, input int fb);
    logic [38:0] cw;
    exp_t        e;
    int          nflips;
    cw = ref_encode(d);
    nflips = 0;
    if (fa >= 0) begin cw = cw ^ (39'd1 << fa); nflips++; end
    if (fb >= 0) begin cw = cw ^ (39'd1 << fb); nflips++; end
    e.sbe  = (nflips == 1);
    e.dbe  = (nflips == 2);
    e.data = (nflips == 2) ? ref_extract(cw) : d;
    if (e.sbe) exp_sbe++;
    if (e.dbe) exp_dbe++;
    mem[wr_ptr[3:0]] = cw;
    wr_ptr = wr_ptr + 5'd1;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag);
    int n;
    head.ready = 1'b1;
    n = 0;
    while ((sb.size() != 0 || head.valid) && n < 300) begin
      tick();
      n++;
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  // Every valid head is compared with the oldest outstanding expected entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (head.valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 64'(head.valid), 64'd0);
        end else begin
          check("head_data", 64'(head.data), 64'(sb[0].data));
          check("head_sbe",  64'(head.sbe),  64'(sb[0].sbe));
          check("head_dbe",  64'(head.dbe),  64'(sb[0].dbe));
          if (head.ready) void'(sb.pop_front());
        end
      end
      if (prev_rd == 5'd31 && rd_ptr == 5'd0) saw_wrap = 1'b1;
      prev_rd = rd_ptr;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] rd_start;
    int         r, fa, fb;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    head.ready = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_rd_ptr",    64'(rd_ptr),     64'd0);
    check("rst_rd_en",     64'(mem_rd_en),  64'd0);
    check("rst_valid",     64'(head.valid), 64'd0);
    check("rst_data",      64'(head.data),  64'd0);
    check("rst_sbe_count", 64'(sbe_count),  64'd0);
    check("rst_dbe_count", 64'(dbe_count),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single clean word latency
    write_word(32'hDEADBEEF, -1, -1);
    @(negedge clk);
    check("lat_rd_en_e1",  64'(mem_rd_en),   64'd1);
    check("lat_rd_addr",   64'(mem_rd_addr), 64'd0);
    check("lat_valid_e1",  64'(head.valid),  64'd0);
    tick();
    @(negedge clk);
    check("lat_valid_e2",  64'(head.valid),  64'd0);
    tick();
    @(negedge clk);
    check("lat_valid_e3",  64'(head.valid),  64'd1);
    check("lat_data",      64'(head.data),   64'hDEADBEEF);
    tick();
    drain("drain_first");

    // Fill 16 with consumer stalled, then stream out at full rate
    head.ready = 1'b0;
    rd_start = rd_ptr;
    for (int i = 0; i < 16; i++) begin
      write_word($urandom, -1, -1);
      tick();
    end
    repeat (3) tick();
    @(negedge clk);
    check("fill_rd_ptr", 64'(rd_ptr),     64'(5'(rd_start + 5'd2)));
    check("fill_rd_en",  64'(mem_rd_en),  64'd0);
    check("fill_valid",  64'(head.valid), 64'd1);
    tick();
    head.ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("stream_no_gap", 64'(head.valid), 64'd1);
      tick();
    end
    drain("drain_stream");

    // Directed error cases
    write_word(32'h12345678, 5, -1);
    drain("drain_sbe5");
    check("sbe_count_1", 64'(sbe_count), 64'd1);
    write_word(32'hA5A5F00F, 0, -1);
    drain("drain_sbe0");
    check("sbe_count_2", 64'(sbe_count), 64'd2);
    write_word(32'h0BADF00D, 3, 9);
    drain("drain_dbe");
    check("dbe_count_1", 64'(dbe_count), 64'd1);
    write_word(32'hCAFEF00D, -1, -1);
    drain("drain_clean");
    check("sbe_count_keep", 64'(sbe_count), 64'(exp_sbe));
    check("dbe_count_keep", 64'(dbe_count), 64'(exp_dbe));

    // Randomized traffic with random backpressure; wraps the pointers several times
    for (int it = 0; it < 500; it++) begin
      tick();
      head.ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && 5'(wr_ptr - rd_ptr) < 5'd16) begin
        r  = int'($urandom_range(0, 9));
        fa = -1;
        fb = -1;
        if (r >= 7) fa = int'($urandom_range(0, 38));
        if (r == 9) begin
          fb = int'($urandom_range(0, 37));
          if (fb >= fa) fb++;
        end
        write_word($urandom, fa, fb);
      end
    end
    drain("drain_random");
    check("rand_rd_ptr",    64'(rd_ptr),    64'(wr_ptr));
    check("rand_wrap_seen", 64'(saw_wrap),  64'd1);
    check("rand_sbe_count", 64'(sbe_count), 64'(exp_sbe));
    check("rand_dbe_count", 64'(dbe_count), 64'(exp_dbe));

    // Reset with a read in flight and the buffer about to fill
    head.ready = 1'b0;
    tick();
    write_word(32'h11111111, -1, -1);
    tick();
    write_word(32'h22222222, -1, -1);
    tick();
    check("pre_rst_valid", 64'(head.valid), 64'd1);
    rst_n  = 1'b0;
    wr_ptr = '0;
    sb.delete();
    exp_sbe = 0;
    exp_dbe = 0;
    tick();
    @(negedge clk);
    check("mid_rst_valid",     64'(head.valid), 64'd0);
    check("mid_rst_rd_ptr",    64'(rd_ptr),     64'd0);
    check("mid_rst_sbe_count", 64'(sbe_count),  64'd0);
    check("mid_rst_dbe_count", 64'(dbe_count),  64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", 64'(head.valid), 64'd0);
      tick();
    end
    write_word(32'h33333333, -1, -1);
    write_word(32'h44444444, 7, -1);
    drain("drain_post_rst");
    check("post_rst_sbe_count", 64'(sbe_count), 64'(exp_sbe));
    check("post_rst_rd_ptr",    64'(rd_ptr),    64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
